// File: rtl/l2_cache_pkg.sv
// Shared types and address-field widths for the L2 cache.
// The word address is always 15 bits; field widths follow the line geometry.
package l2_cache_pkg;

  localparam int ADDR_W = 15;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } l2_state_t;

  function automatic int offset_bits(int block_size);
    return $clog2(block_size);
  endfunction

  function automatic int index_bits(int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_bits(int block_size, int num_lines);
    return ADDR_W - $clog2(block_size) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/l2_data_ram.sv
// Cache data array: one synchronous write port, one combinational read port.
module l2_data_ram #(
  parameter int n     = 32,
  parameter int depth = 1024,
  parameter int aw    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [n-1:0]  wdata,
  input  logic [aw-1:0] raddr,
  output logic [n-1:0]  rdata
);

  logic [n-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/l2_cache.sv
// Direct-mapped, write-back, write-allocate L2 cache with a 4-state controller.
// Define L2_STATS_EN to enable the saturating hit/miss counters on L2_statistics.
module l2_cache
  import l2_cache_pkg::*;
#(
  parameter int n          = 32,
  parameter int block_size = 16,
  parameter int num_lines  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] L1_word_address,
  input  logic [n-1:0]      L1_wdata,
  input  logic              L1_write_request,
  input  logic              L1_read_request,
  input  logic [n-1:0]      MM_read_word,
  output logic [n-1:0]      L1_rdata,
  output logic [ADDR_W-1:0] MM_word_address,
  output logic [n-1:0]      MM_write_word,
  output logic              MM_read_request,
  output logic              MM_write_request,
  output logic              L2_busy,
  output logic [31:0]       L2_statistics
);

  localparam int off_w  = offset_bits(block_size);
  localparam int idx_w  = index_bits(num_lines);
  localparam int tag_w  = tag_bits(block_size, num_lines);
  localparam int ram_aw = off_w + idx_w;

  l2_state_t          state;
  logic [ADDR_W-1:0]  addr_q;
  logic [n-1:0]       wdata_q;
  logic               write_q;
  logic [off_w-1:0]   cnt;
  logic [num_lines-1:0] valid;
  logic [num_lines-1:0] dirty;
  logic [tag_w-1:0]   tags [num_lines];

  logic [tag_w-1:0]   req_tag, vic_tag;
  logic [idx_w-1:0]   req_idx;
  logic [off_w-1:0]   req_off, next_off, zero_off;
  logic               hit, last;

  logic               ram_we;
  logic [ram_aw-1:0]  ram_waddr, ram_raddr;
  logic [n-1:0]       ram_wdata, ram_rdata;

  assign req_tag  = addr_q[ADDR_W-1 -: tag_w];
  assign req_idx  = addr_q[off_w +: idx_w];
  assign req_off  = addr_q[off_w-1:0];
  assign vic_tag  = tags[req_idx];
  assign next_off = cnt + off_w'(1);
  assign zero_off = '0;
  assign hit      = valid[req_idx] && (vic_tag == req_tag);
  assign last     = (cnt == off_w'(block_size - 1));
  assign L2_busy  = (state != IDLE);

  // Read port looks one word ahead so the registered MM_write_word lines up with cnt.
  always_comb begin
    ram_raddr = {req_idx, req_off};
    if (state == COMPARE && !hit) ram_raddr = {req_idx, zero_off};
    if (state == WRITEBACK)       ram_raddr = {req_idx, next_off};
    ram_we    = (state == ALLOCATE) || (state == COMPARE && hit && write_q);
    ram_waddr = (state == ALLOCATE) ? {req_idx, cnt} : {req_idx, req_off};
    ram_wdata = (state == ALLOCATE) ? MM_read_word : wdata_q;
  end

  l2_data_ram #(
    .n    (n),
    .depth(num_lines * block_size),
    .aw   (ram_aw)
  ) u_data_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      addr_q           <= '0;
      wdata_q          <= '0;
      write_q          <= 1'b0;
      cnt              <= '0;
      valid            <= '0;
      dirty            <= '0;
      L1_rdata         <= '0;
      MM_word_address  <= '0;
      MM_write_word    <= '0;
      MM_read_request  <= 1'b0;
      MM_write_request <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (L1_write_request || L1_read_request) begin
            addr_q  <= L1_word_address;
            wdata_q <= L1_wdata;
            write_q <= L1_write_request;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          cnt <= '0;
          if (hit) begin
            if (write_q) dirty[req_idx] <= 1'b1;
            else         L1_rdata       <= ram_rdata;
            state <= IDLE;
          end else if (valid[req_idx] && dirty[req_idx]) begin
            MM_write_request <= 1'b1;
            MM_word_address  <= {vic_tag, req_idx, zero_off};
            MM_write_word    <= ram_rdata;
            state            <= WRITEBACK;
          end else begin
            MM_read_request <= 1'b1;
            MM_word_address <= {req_tag, req_idx, zero_off};
            state           <= ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (last) begin
            cnt              <= '0;
            MM_write_request <= 1'b0;
            MM_read_request  <= 1'b1;
            MM_word_address  <= {req_tag, req_idx, zero_off};
            state            <= ALLOCATE;
          end else begin
            cnt             <= next_off;
            MM_word_address <= {vic_tag, req_idx, next_off};
            MM_write_word   <= ram_rdata;
          end
        end
        ALLOCATE: begin
          if (last) begin
            cnt             <= '0;
            MM_read_request <= 1'b0;
            MM_word_address <= '0;
            valid[req_idx]  <= 1'b1;
            dirty[req_idx]  <= 1'b0;
            state           <= COMPARE;
          end else begin
            cnt             <= next_off;
            MM_word_address <= {req_tag, req_idx, next_off};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (state == ALLOCATE && last) tags[req_idx] <= req_tag;
  end

`ifdef L2_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
  logic        refill;

  // refill marks the completing COMPARE after ALLOCATE, which is not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      refill   <= 1'b0;
    end else begin
      if (state == ALLOCATE)  refill <= 1'b1;
      else if (state == IDLE) refill <= 1'b0;
      if (state == COMPARE) begin
        if (hit) begin
          if (!refill && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
        end else if (miss_cnt != 16'hFFFF) begin
          miss_cnt <= miss_cnt + 16'd1;
        end
      end
    end
  end

  assign L2_statistics = {hit_cnt, miss_cnt};
`else
  assign L2_statistics = '0;
`endif

endmodule

// File: tb/tb_l2_cache.sv
// Self-checking bench for l2_cache: directed scenarios then randomized accesses
// compared against an array-based cache/memory reference model.
module tb_l2_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] L1_word_address = '0;
  logic [31:0] L1_wdata = '0;
  logic        L1_write_request = 1'b0;
  logic        L1_read_request = 1'b0;
  logic [31:0] MM_read_word = '0;
  logic [31:0] L1_rdata;
  logic [14:0] MM_word_address;
  logic [31:0] MM_write_word;
  logic        MM_read_request;
  logic        MM_write_request;
  logic        L2_busy;
  logic [31:0] L2_statistics;

  always #5 clk = ~clk;

  l2_cache dut (
    .clk             (clk),
    .reset           (reset),
    .L1_word_address (L1_word_address),
    .L1_wdata        (L1_wdata),
    .L1_write_request(L1_write_request),
    .L1_read_request (L1_read_request),
    .MM_read_word    (MM_read_word),
    .L1_rdata        (L1_rdata),
    .MM_word_address (MM_word_address),
    .MM_write_word   (MM_write_word),
    .MM_read_request (MM_read_request),
    .MM_write_request(MM_write_request),
    .L2_busy         (L2_busy),
    .L2_statistics   (L2_statistics)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: 64 lines x 16 words, tag = addr/1024, index = (addr/16)%64.
  bit          m_valid [64];
  bit          m_dirty [64];
  int          m_tag   [64];
  logic [31:0] m_data  [64][16];
  logic [31:0] ref_mm  [int];
  logic [31:0] resp_mm [int];
  int          exp_hits = 0;
  int          exp_misses = 0;
  logic [31:0] exp_rdata = '0;

  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          rd_addr_q[$];
  int          exp_wr_addr[$];
  logic [31:0] exp_wr_data[$];
  int          exp_rd_addr[$];

  function automatic logic [31:0] mm_default(int a);
    return (a < 2048) ? 32'(5 * (a % 16)) : 32'(a * 7 + 3);
  endfunction

  function automatic logic [31:0] ref_get(int a);
    return ref_mm.exists(a) ? ref_mm[a] : mm_default(a);
  endfunction

  function automatic logic [31:0] resp_get(int a);
    return resp_mm.exists(a) ? resp_mm[a] : mm_default(a);
  endfunction

  function automatic logic [31:0] exp_stats();
`ifdef L2_STATS_EN
    return {exp_hits[15:0], exp_misses[15:0]};
`else
    return 32'd0;
`endif
  endfunction

  // Main-memory responder and traffic monitor.
  always @(negedge clk) begin
    if (reset && MM_write_request) begin
      wr_addr_q.push_back(int'(MM_word_address));
      wr_data_q.push_back(MM_write_word);
      resp_mm[int'(MM_word_address)] = MM_write_word;
    end
    if (reset && MM_read_request) begin
      rd_addr_q.push_back(int'(MM_word_address));
      MM_read_word = resp_get(int'(MM_word_address));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_hits   = 0;
    exp_misses = 0;
    exp_rdata  = '0;
  endtask

  task automatic model_access(int a, bit w, logic [31:0] wd, output bit was_hit);
    int idx, tg, off;
    idx = (a / 16) % 64;
    tg  = a / 1024;
    off = a % 16;
    exp_wr_addr.delete();
    exp_wr_data.delete();
    exp_rd_addr.delete();
    was_hit = m_valid[idx] && (m_tag[idx] == tg);
    if (was_hit) begin
      if (exp_hits < 65535) exp_hits++;
    end else begin
      if (exp_misses < 65535) exp_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int k = 0; k < 16; k++) begin
          int va;
          va = m_tag[idx] * 1024 + idx * 16 + k;
          exp_wr_addr.push_back(va);
          exp_wr_data.push_back(m_data[idx][k]);
          ref_mm[va] = m_data[idx][k];
        end
      end
      for (int k = 0; k < 16; k++) begin
        int na;
        na = tg * 1024 + idx * 16 + k;
        exp_rd_addr.push_back(na);
        m_data[idx][k] = ref_get(na);
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    if (w) begin
      m_data[idx][off] = wd;
      m_dirty[idx]     = 1'b1;
    end else begin
      exp_rdata = m_data[idx][off];
    end
  endtask

  task automatic check_traffic();
    int nw, nr;
    check("wr_count", 64'(wr_addr_q.size()), 64'(exp_wr_addr.size()));
    nw = (wr_addr_q.size() < exp_wr_addr.size()) ? wr_addr_q.size() : exp_wr_addr.size();
    for (int i = 0; i < nw; i++) begin
      check("wb_addr", 64'(wr_addr_q[i]), 64'(exp_wr_addr[i]));
      check("wb_data", 64'(wr_data_q[i]), 64'(exp_wr_data[i]));
    end
    check("rd_count", 64'(rd_addr_q.size()), 64'(exp_rd_addr.size()));
    nr = (rd_addr_q.size() < exp_rd_addr.size()) ? rd_addr_q.size() : exp_rd_addr.size();
    for (int i = 0; i < nr; i++) check("alloc_addr", 64'(rd_addr_q[i]), 64'(exp_rd_addr[i]));
  endtask

  task automatic do_access(int a, bit w, bit r, logic [31:0] wd);
    bit hit;
    int waited;
    model_access(a, w, wd, hit);
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    L1_word_address  = 15'(a);
    L1_wdata         = wd;
    L1_write_request = w;
    L1_read_request  = r;
    @(posedge clk);
    #1;
    L1_write_request = 1'b0;
    L1_read_request  = 1'b0;
    @(negedge clk);
    check("busy_after_sample", 64'(L2_busy), 64'(1));
    if (hit) begin
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("hit_latency_busy", 64'(L2_busy), 64'(0));
    end else begin
      waited = 0;
      while (L2_busy && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      check("miss_complete", 64'(L2_busy), 64'(0));
    end
    check("l1_rdata", 64'(L1_rdata), 64'(exp_rdata));
    check("statistics", 64'(L2_statistics), 64'(exp_stats()));
    check("mm_req_idle", 64'({MM_read_request, MM_write_request}), 64'(0));
    check_traffic();
    $display("access addr=%0d wr=%0d rd=%0d hit=%0d rdata=%0h stats=%0h",
             a, w, r, hit, L1_rdata, L2_statistics);
  endtask

  initial begin
    int waited;
    model_reset();
    #2;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(L2_busy), 64'(0));
    check("reset_rdata", 64'(L1_rdata), 64'(0));
    check("reset_mm", 64'({MM_read_request, MM_write_request, MM_word_address, MM_write_word}), 64'(0));
    check("reset_stats", 64'(L2_statistics), 64'(0));
    reset = 1'b1;

    do_access(1000, 1'b1, 1'b0, 32'd8);        // cold write miss
    do_access(1000, 1'b0, 1'b1, 32'd0);        // read hit -> 8
    do_access(1001, 1'b0, 1'b1, 32'd0);        // read hit -> 45
    do_access(2024, 1'b0, 1'b1, 32'd0);        // conflict: writeback then allocate
    do_access(1000, 1'b1, 1'b1, 32'hABCD);     // both requests: write wins

    // Abort an allocate with reset.
    @(negedge clk);
    L1_word_address = 15'd3000;
    L1_read_request = 1'b1;
    @(posedge clk);
    #1;
    L1_read_request = 1'b0;
    waited = 0;
    while (!MM_read_request && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("alloc_started", 64'(MM_read_request), 64'(1));
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check("abort_busy", 64'(L2_busy), 64'(0));
    check("abort_mm", 64'({MM_read_request, MM_write_request, MM_word_address}), 64'(0));
    check("abort_stats", 64'(L2_statistics), 64'(0));
    check("abort_rdata", 64'(L1_rdata), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    $display("reset asserted mid-allocate");

    do_access(1000, 1'b0, 1'b1, 32'd0);        // must miss after reset

    for (int i = 0; i < 40; i++) begin
      int tg, idx, off, op, sel;
      tg  = int'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 3));
      idx = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 62 : int'($urandom_range(0, 63));
      off = int'($urandom_range(0, 15));
      op  = int'($urandom_range(0, 2));
      do_access(tg * 1024 + idx * 16 + off, op != 0, op != 1, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
